uart_tx_arbiter: RTL



---
 rtl/uart_tx_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler for two byte sources in front of the shared UART transmitter.
// Define UART_ARB_FIXED_PRIO_EN to give channel 0 strict priority instead of round-robin.
module uart_tx_arbiter #(
    parameter int unsigned BIT_CYCLES = 20834,
    parameter int unsigned FRAME_BITS = 10,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned CNT_W      = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       tx_key,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       gnt_id
);

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        WAIT
    } state_t;

    // WAIT exits on the edge where the counter reaches P-1, so the next grant
    // lands exactly P clocks after the previous one under continuous requests.
    localparam logic [CNT_W-1:0] END_CNT =
        CNT_W'(BIT_CYCLES * FRAME_BITS + GAP_CYCLES - 2);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             last, last_nxt;
    logic             any_req, win;
    logic             tx_key_nxt, ack0_nxt, ack1_nxt, busy_nxt, gnt_id_nxt;
    logic [7:0]       tx_data_nxt;

    always_comb begin
        any_req = req0 | req1;
`ifdef UART_ARB_FIXED_PRIO_EN
        win = ~req0;
`else
        win = (req0 && req1) ? ~last : req1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            last    <= 1'b1;
            tx_key  <= 1'b1;
            tx_data <= '0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            busy    <= 1'b0;
            gnt_id  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            last    <= last_nxt;
            tx_key  <= tx_key_nxt;
            tx_data <= tx_data_nxt;
            ack0    <= ack0_nxt;
            ack1    <= ack1_nxt;
            busy    <= busy_nxt;
            gnt_id  <= gnt_id_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = FIRE;
            FIRE:    state_nxt = WAIT;
            WAIT:    if (cnt == END_CNT) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt     = cnt;
        last_nxt    = last;
        tx_key_nxt  = 1'b1;
        tx_data_nxt = tx_data;
        ack0_nxt    = 1'b0;
        ack1_nxt    = 1'b0;
        busy_nxt    = busy;
        gnt_id_nxt  = gnt_id;
        case (state)
            IDLE: begin
                if (any_req) begin
                    tx_data_nxt = win ? data1 : data0;
                    ack0_nxt    = ~win;
                    ack1_nxt    = win;
                    tx_key_nxt  = 1'b0;
                    busy_nxt    = 1'b1;
                    gnt_id_nxt  = win;
                    last_nxt    = win;
                    cnt_nxt     = '0;
                end
            end
            FIRE: cnt_nxt = cnt + CNT_W'(1);
            WAIT: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == END_CNT) busy_nxt = 1'b0;
            end
            default: begin
                cnt_nxt  = '0;
                busy_nxt = 1'b0;
            end
        endcase
    end

endmodule
